// File: rtl/scpu_pkg.sv
// Shared definitions for the SCPU multi-cycle controller: opcodes, FSM
// state encoding, write-back selects and trap causes.
package scpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TMO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TMO = 2'b11;

  // True for the RV64I major opcodes this core implements.
  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: opc_legal = 1'b1;
      default:                               opc_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// 8-bit memory wait counter. expire fires on the waiting cycle that would
// bring the count to LIMIT, so a ready on that same cycle still wins.
module ctrl_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] r_cnt;

  // Count unstalled waiting cycles; cleared on entry to a waiting state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expire = en && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the SCPU core. Walks FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes, counts retired instructions and traps on
// illegal opcodes or memory timeouts.
module multicycle_ctrl
  import scpu_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int MEM_TMO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             trap_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             imm_en,
  output logic             alu_src_imm,
  output logic             alu_src_pc,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic             pc_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_opc;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_next;
  logic [CNT_W-1:0] r_instret;
  logic             w_wait;
  logic             w_tmo_en;
  logic             w_tmo_clr;
  logic             w_expire;

  logic w_op, w_load, w_store, w_branch, w_jal, w_jalr, w_lui, w_auipc;

  assign w_op     = (r_opc == OPC_OP);
  assign w_load   = (r_opc == OPC_LOAD);
  assign w_store  = (r_opc == OPC_STORE);
  assign w_branch = (r_opc == OPC_BRANCH);
  assign w_jal    = (r_opc == OPC_JAL);
  assign w_jalr   = (r_opc == OPC_JALR);
  assign w_lui    = (r_opc == OPC_LUI);
  assign w_auipc  = (r_opc == OPC_AUIPC);

  // A waiting cycle is a memory state whose handshake has not completed.
  assign w_wait    = ((r_state == ST_FETCH) && !imem_ready) ||
                     ((r_state == ST_MEM)   && !dmem_ready);
  assign w_tmo_en  = w_wait && !stall;
  assign w_tmo_clr = !stall && (w_next != r_state) &&
                     ((w_next == ST_FETCH) || (w_next == ST_MEM));

  ctrl_timeout #(
    .LIMIT (MEM_TMO)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_tmo_clr),
    .en     (w_tmo_en),
    .expire (w_expire)
  );

  // Next-state and trap-cause selection; stall freezes everything.
  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    if (!stall) begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            w_next = ST_DECODE;
          end else if (w_expire) begin
            w_next       = ST_TRAP;
            w_cause_next = CAUSE_IMEM_TMO;
          end
        end
        ST_DECODE: begin
          if (opc_legal(opcode)) begin
            w_next = ST_EXEC;
          end else begin
            w_next       = ST_TRAP;
            w_cause_next = CAUSE_ILLEGAL;
          end
        end
        ST_EXEC: begin
          if (w_load || w_store) w_next = ST_MEM;
          else if (w_branch)     w_next = ST_FETCH;
          else                   w_next = ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) begin
            w_next = w_load ? ST_WB : ST_FETCH;
          end else if (w_expire) begin
            w_next       = ST_TRAP;
            w_cause_next = CAUSE_DMEM_TMO;
          end
        end
        ST_WB: w_next = ST_FETCH;
        ST_TRAP: begin
          if (trap_ack) begin
            w_next       = ST_FETCH;
            w_cause_next = CAUSE_NONE;
          end
        end
        default: w_next = ST_FETCH;
      endcase
    end
  end

  // State, trap cause and the opcode captured as DECODE is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_cause <= CAUSE_NONE;
      r_opc   <= '0;
    end else if (!stall) begin
      r_state <= w_next;
      r_cause <= w_cause_next;
      if (r_state == ST_DECODE) r_opc <= opcode;
    end
  end

  // Retired-instruction counter advances once per PC update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (pc_we) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Datapath strobes; reset drops them immediately, stall kills the pulses.
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    imm_en      = 1'b0;
    alu_src_imm = 1'b0;
    alu_src_pc  = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready && !stall;
        end
        ST_DECODE: imm_en = 1'b1;
        ST_EXEC: begin
          alu_src_imm = !(w_op || w_branch);
          alu_src_pc  = w_auipc || w_jal;
          if (w_branch) begin
            pc_we  = !stall;
            pc_src = branch_taken;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = w_store;
          if (w_store && dmem_ready) pc_we = !stall;
        end
        ST_WB: begin
          reg_we = !stall;
          pc_we  = !stall;
          pc_src = w_jal || w_jalr;
          if (w_load)               wb_sel = WB_MEM;
          else if (w_jal || w_jalr) wb_sel = WB_PC4;
          else if (w_lui)           wb_sel = WB_IMM;
          else                      wb_sel = WB_ALU;
        end
        default: ;
      endcase
    end
  end

  assign trap       = (r_state == ST_TRAP) && !rst;
  assign trap_cause = r_cause;
  assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver issues instructions and
// pushes the expected retirement/trap record; a monitor pops on each event.
module tb_multicycle_ctrl;

  localparam logic [6:0] C_OP  = 7'b0110011, C_IMM = 7'b0010011, C_LD  = 7'b0000011;
  localparam logic [6:0] C_ST  = 7'b0100011, C_BR  = 7'b1100011, C_JAL = 7'b1101111;
  localparam logic [6:0] C_JR  = 7'b1100111, C_LUI = 7'b0110111, C_AUI = 7'b0010111;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0;
  logic branch_taken = 0, stall = 0, imem_ready = 0, dmem_ready = 0, trap_ack = 0;
  logic imem_req, ir_we, imm_en, alu_src_imm, alu_src_pc, dmem_req, dmem_we;
  logic reg_we, pc_we, pc_src, trap;
  logic [1:0] wb_sel, trap_cause;
  logic [63:0] instret;

  multicycle_ctrl #(.CNT_W(64), .MEM_TMO(255)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .stall(stall),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .trap_ack(trap_ack),
    .imem_req(imem_req), .ir_we(ir_we), .imm_en(imm_en), .alu_src_imm(alu_src_imm),
    .alu_src_pc(alu_src_pc), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    logic [1:0]  cause;
    bit          pc_src;
    bit          reg_we;
    logic [1:0]  wb_sel;
    longint      instret;
    int          req;
    int          dm;
    bit          dwe;
    int          lat;
    bit          aimm;
    bit          apc;
  } exp_t;

  exp_t   q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint model_ret = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: what one instruction must produce, from its opcode class and
  // the memory/stall wait cycles the driver will apply.
  function automatic exp_t model(input logic [6:0] opc, input int wi, input int wd,
                                 input int stl, input bit bt);
    exp_t e;
    bit ld, st, br, jmp;
    e = '{default: 0};
    e.instret = model_ret;
    e.req = wi + 1;
    if (!(opc inside {C_OP, C_IMM, C_LD, C_ST, C_BR, C_JAL, C_JR, C_LUI, C_AUI})) begin
      e.is_trap = 1; e.cause = 2'b01; e.dm = 0; e.lat = -1;
      return e;
    end
    ld = (opc == C_LD); st = (opc == C_ST); br = (opc == C_BR);
    jmp = (opc == C_JAL) || (opc == C_JR);
    e.aimm = !(opc == C_OP || br);
    e.apc  = (opc == C_AUI) || (opc == C_JAL);
    if (br) begin
      e.pc_src = bt; e.lat = 2; e.dm = 0;
    end else if (st) begin
      e.dm = wd + 1; e.dwe = 1; e.lat = 3 + wd + stl;
    end else begin
      e.reg_we = 1;
      e.pc_src = jmp;
      e.wb_sel = ld ? 2'b01 : jmp ? 2'b10 : (opc == C_LUI) ? 2'b11 : 2'b00;
      e.lat    = ld ? 4 + wd + stl : 3;
      e.dm     = ld ? wd + 1 : 0;
    end
    return e;
  endfunction

  // Monitor: samples 2ns after each falling edge and scores every event.
  initial begin
    int cyc = 0, t_ir = -100, req_cnt = 0, dm_cnt = 0;
    bit dwe_seen = 0, imm_seen = 0, aimm_c = 0, apc_c = 0, prev_trap = 0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (rst) begin
        req_cnt = 0; dm_cnt = 0; dwe_seen = 0; prev_trap = 0; t_ir = -100;
        continue;
      end
      if (!stall && imem_req) req_cnt++;
      if (!stall && dmem_req) begin dm_cnt++; if (dmem_we) dwe_seen = 1; end
      if (ir_we) t_ir = cyc;
      if (cyc == t_ir + 1) imm_seen = imm_en;
      if (cyc == t_ir + 2) begin aimm_c = alu_src_imm; apc_c = alu_src_pc; end
      if (stall && (ir_we || reg_we || pc_we)) check("strobe_under_stall", 1, 0);
      if (reg_we && !pc_we) check("reg_we_without_pc_we", 1, 0);
      if (trap && (imem_req || dmem_req || pc_we || reg_we || ir_we)) check("strobe_in_trap", 1, 0);
      if (pc_we || (trap && !prev_trap)) begin
        if (q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          check("event_kind", pc_we ? 0 : 1, e.is_trap);
          check("instret", instret, e.instret);
          check("imem_req_cycles", req_cnt, e.req);
          if (e.dm >= 0) check("dmem_req_cycles", dm_cnt, e.dm);
          if (e.is_trap) begin
            check("trap_cause", trap_cause, e.cause);
            if (e.cause == 2'b01) check("imm_en_decode", imm_seen, 1);
          end else begin
            check("pc_src", pc_src, e.pc_src);
            check("reg_we", reg_we, e.reg_we);
            if (e.reg_we) check("wb_sel", wb_sel, e.wb_sel);
            check("dmem_we", dwe_seen, e.dwe);
            check("latency", cyc - t_ir, e.lat);
            check("imm_en_decode", imm_seen, 1);
            check("alu_src_imm", aimm_c, e.aimm);
            check("alu_src_pc", apc_c, e.apc);
          end
        end
        req_cnt = 0; dm_cnt = 0; dwe_seen = 0;
      end
      prev_trap = trap;
    end
  end

  task automatic wait_sig(input int which, output bit ok);
    int n = 0;
    ok = 1;
    while (!(which == 0 ? imem_req : which == 1 ? dmem_req : trap)) begin
      @(negedge clk);
      n++;
      if (n > 600) begin
        check("wait_bound", which, 99);
        ok = 0;
        return;
      end
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_outs"}, {imem_req, ir_we, imm_en, alu_src_imm, alu_src_pc, dmem_req,
                          dmem_we, reg_we, wb_sel, pc_we, pc_src, trap, trap_cause}, 0);
    check({nm, "_instret"}, instret, 0);
  endtask

  task automatic ack_trap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    trap_ack = 1;
    @(negedge clk);
    trap_ack = 0;
    #1;
    check("ack_imem_req", imem_req, 1);
    check("ack_trap_low", trap, 0);
    check("ack_cause_clear", trap_cause, 0);
  endtask

  task automatic fetch(input logic [6:0] opc, input int wi, input bit bt, output bit ok);
    wait_sig(0, ok);
    if (!ok) return;
    opcode = opc; branch_taken = bt;
    repeat (wi) @(negedge clk);
    imem_ready = 1;
    @(negedge clk);
    imem_ready = 0;
  endtask

  task automatic run_instr(input logic [6:0] opc, input int wi, input int wd, input bit bt);
    exp_t e;
    bit ok;
    e = model(opc, wi, wd, 0, bt);
    q.push_back(e);
    if (!e.is_trap) model_ret++;
    fetch(opc, wi, bt, ok);
    if (!ok) return;
    if (e.is_trap) begin
      wait_sig(2, ok);
      if (ok) ack_trap();
    end else if (opc == C_LD || opc == C_ST) begin
      wait_sig(1, ok);
      if (!ok) return;
      repeat (wd) @(negedge clk);
      dmem_ready = 1;
      @(negedge clk);
      dmem_ready = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [6:0] legal [9];
    logic [6:0] opc;
    exp_t e;
    bit ok;
    legal = '{C_OP, C_IMM, C_LD, C_ST, C_BR, C_JAL, C_JR, C_LUI, C_AUI};

    // Reset state
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 0;
    #1 check("post_reset_imem_req", imem_req, 1);

    // Directed cases
    run_instr(C_IMM, 0, 0, 0);
    run_instr(C_LD, 0, 2, 0);
    run_instr(C_ST, 0, 2, 0);
    run_instr(C_BR, 0, 0, 1);
    run_instr(C_BR, 1, 0, 0);
    run_instr(7'b0000000, 0, 0, 0);
    run_instr(C_LUI, 0, 0, 0);
    run_instr(C_JAL, 2, 0, 0);
    run_instr(C_AUI, 0, 0, 0);

    // imem never ready: trap after 255 waiting cycles
    e = '{default: 0};
    e.is_trap = 1; e.cause = 2'b10; e.req = 255; e.dm = 0; e.instret = model_ret; e.lat = -1;
    q.push_back(e);
    wait_sig(0, ok);
    if (ok) wait_sig(2, ok);
    if (ok) ack_trap();

    // Ready on the 255th waiting cycle wins over the timeout
    run_instr(C_OP, 254, 0, 0);

    // dmem never ready: trap after 255 MEM cycles
    e = '{default: 0};
    e.is_trap = 1; e.cause = 2'b11; e.req = 1; e.dm = 255; e.instret = model_ret; e.lat = -1;
    q.push_back(e);
    fetch(C_LD, 0, 0, ok);
    if (ok) wait_sig(2, ok);
    if (ok) ack_trap();

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) opc = 7'($urandom_range(0, 127));
      else                           opc = legal[$urandom_range(0, 8)];
      run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Long stall in MEM holds the timeout; then reset during WB
    e = model(C_LD, 1, 2, 300, 0);
    q.push_back(e);
    model_ret++;
    fetch(C_LD, 1, 0, ok);
    if (ok) wait_sig(1, ok);
    if (ok) begin
      stall = 1;
      for (int i = 0; i < 300; i++) begin
        dmem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      stall = 0;
      dmem_ready = 0;
      repeat (2) @(negedge clk);
      dmem_ready = 1;
      @(negedge clk);
      dmem_ready = 0;
      #3 check("wb_before_reset", reg_we, 1);
      rst = 1;
      #1 check_all_zero("async_reset_in_wb");
      @(negedge clk);
      rst = 0;
      model_ret = 0;
      #1;
    end
    run_instr(C_JR, 0, 0, 0);
    run_instr(C_IMM, 0, 0, 0);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
